// File: rtl/cv32e20_sim_pkg.sv
// Shared constants and helpers for the cv32e20 simulation harness:
// peripheral address map, test status codes and byte-enable merging.
package cv32e20_sim_pkg;

  localparam logic [31:0] PRINT_ADDR       = 32'h1000_0000;
  localparam logic [31:0] TIMER_CNT_ADDR   = 32'h1500_0000;
  localparam logic [31:0] TIMER_CTRL_ADDR  = 32'h1500_0004;
  localparam logic [31:0] TEST_STATUS_ADDR = 32'h2000_0000;
  localparam logic [31:0] EXIT_ADDR        = 32'h2000_0004;

  localparam logic [31:0] TEST_PASS_MAGIC  = 32'd123456789;
  localparam logic [31:0] TEST_FAIL_CODE   = 32'd1;

  // Multi-bit fetch-enable encoding expected by the core.
  localparam logic [3:0]  FETCH_ON         = 4'b0101;
  localparam logic [3:0]  FETCH_OFF        = 4'b1010;

  // Source of the registered data-port read response.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_PERIPH
  } rd_sel_e;

  // Replace the bytes of old_val selected by be with the matching bytes of wdata.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cv32e20_sim_harness_core.sv
// Fetch-only stand-in for the cv32e20 core. Once fetch is enabled it streams
// sequential instruction fetches from the boot vector; the data port idles so
// another bus master can exercise the memory map.
//
// state     | meaning
// ----------+---------------------------------------------
// CORE_IDLE | fetch disabled, no requests issued
// CORE_RUN  | one fetch per cycle, address advances on gnt
module cv32e20_core_model
  import cv32e20_sim_pkg::*;
#(
  parameter logic [31:0] DM_HALTADDRESS   = 32'h1A11_0800,
  parameter int unsigned MHPMCounterNum   = 10,
  parameter int unsigned MHPMCounterWidth = 40,
  parameter bit          RV32E            = 1'b0,
  parameter int          RV32M            = 2
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic [3:0]  fetch_enable,
  input  logic [31:0] boot_addr,
  output logic        instr_req,
  input  logic        instr_gnt,
  input  logic        instr_rvalid,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_rdata,
  input  logic        instr_err,
  output logic        data_req,
  input  logic        data_gnt,
  input  logic        data_rvalid,
  output logic        data_we,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_err,
  input  logic        irq_software,
  input  logic        irq_timer,
  input  logic        irq_external,
  input  logic        irq_nmi,
  input  logic        debug_req
);

  typedef enum logic [0:0] {
    CORE_IDLE,
    CORE_RUN
  } core_state_e;

  core_state_e state;
  logic        unused_inputs;
  logic        unused_cfg;

  assign unused_inputs = ^{instr_rvalid, instr_rdata, instr_err, data_gnt, data_rvalid,
                           data_rdata, data_err, irq_software, irq_timer, irq_external,
                           irq_nmi, debug_req, boot_addr[7:0]};
  assign unused_cfg    = ^{DM_HALTADDRESS, 32'(MHPMCounterNum), 32'(MHPMCounterWidth),
                           RV32E, 32'(RV32M)};

  // Fetch sequencer; boot vector is the 256-byte-aligned boot address plus 0x80.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state      <= CORE_IDLE;
      instr_req  <= 1'b0;
      instr_addr <= 32'h0;
      data_req   <= 1'b0;
      data_we    <= 1'b0;
      data_be    <= 4'h0;
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
    end else begin
      data_req   <= 1'b0;
      data_we    <= 1'b0;
      data_be    <= 4'h0;
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
      case (state)
        CORE_IDLE: begin
          if (fetch_enable == FETCH_ON) begin
            state      <= CORE_RUN;
            instr_req  <= 1'b1;
            instr_addr <= {boot_addr[31:8], 8'h80};
          end
        end
        CORE_RUN: begin
          if (fetch_enable != FETCH_ON) begin
            state     <= CORE_IDLE;
            instr_req <= 1'b0;
          end else if (instr_gnt) begin
            instr_addr <= instr_addr + 32'd4;
          end
        end
        default: state <= CORE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cv32e20_sim_harness_mm_ram.sv
// Memory subsystem of the harness: address decode, virtual peripherals,
// timer, and the dual-port byte RAM that backs firmware.
module dp_ram #(
  parameter int unsigned INSTR_RDATA_WIDTH = 32,
  parameter int unsigned RAM_ADDR_WIDTH    = 22
) (
  input  logic                         core_clk,
  input  logic                         instr_en,
  input  logic [RAM_ADDR_WIDTH-1:0]    instr_addr,
  output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata,
  input  logic                         data_en,
  input  logic                         data_we,
  input  logic [3:0]                   data_be,
  input  logic [RAM_ADDR_WIDTH-1:0]    data_addr,
  input  logic [31:0]                  data_wdata,
  output logic [31:0]                  data_rdata
);

  localparam int unsigned LINE_BYTES = INSTR_RDATA_WIDTH / 8;

  // Byte array, little-endian; the testbench loads firmware here directly.
  logic [7:0] mem [0:2**RAM_ADDR_WIDTH-1];

  logic [RAM_ADDR_WIDTH-1:0] instr_base;
  logic [RAM_ADDR_WIDTH-1:0] data_base;

  assign instr_base = instr_addr & ~(RAM_ADDR_WIDTH'(LINE_BYTES - 1));
  assign data_base  = data_addr & ~(RAM_ADDR_WIDTH'(3));

  // Instruction port: registered read of one aligned line.
  always_ff @(posedge core_clk) begin
    if (instr_en) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        instr_rdata[8*i +: 8] <= mem[instr_base + RAM_ADDR_WIDTH'(i)];
      end
    end
  end

  // Data port: byte-enabled write, registered read of the old word.
  always_ff @(posedge core_clk) begin
    if (data_en) begin
      for (int i = 0; i < 4; i++) begin
        if (data_we && data_be[i]) mem[data_base + RAM_ADDR_WIDTH'(i)] <= data_wdata[8*i +: 8];
        data_rdata[8*i +: 8] <= mem[data_base + RAM_ADDR_WIDTH'(i)];
      end
    end
  end

endmodule

module mm_ram
  import cv32e20_sim_pkg::*;
#(
  parameter int unsigned INSTR_RDATA_WIDTH = 32,
  parameter int unsigned RAM_ADDR_WIDTH    = 22
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        instr_req,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        data_req,
  output logic        data_gnt,
  output logic        data_rvalid,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        irq_timer,
  output logic        tests_passed,
  output logic        tests_failed,
  output logic        exit_valid,
  output logic [31:0] exit_value
);

  logic                         data_hs;
  logic                         wr_hs;
  logic                         in_ram;
  logic [31:0]                  wdata_masked;
  logic [INSTR_RDATA_WIDTH-1:0] ram_line;
  logic [31:0]                  ram_rdata;
  logic [31:0]                  periph_rdata;
  rd_sel_e                      rd_sel;
  logic [31:0]                  timer_cnt;
  logic                         timer_run;
  logic                         unused_addr_bits;

  // No wait states on either port.
  assign instr_gnt    = instr_req;
  assign data_gnt     = data_req;
  assign instr_err    = 1'b0;
  assign data_err     = 1'b0;

  assign data_hs      = data_req & data_gnt;
  assign wr_hs        = data_hs & data_we;
  assign in_ram       = (data_addr >> RAM_ADDR_WIDTH) == 32'd0;
  assign wdata_masked = be_merge(32'h0, data_wdata, data_be);

  // Instruction fetches wrap inside the RAM; upper address bits are ignored.
  assign unused_addr_bits = ^instr_addr[31:RAM_ADDR_WIDTH];

  dp_ram #(
    .INSTR_RDATA_WIDTH (INSTR_RDATA_WIDTH),
    .RAM_ADDR_WIDTH    (RAM_ADDR_WIDTH)
  ) dp_ram_inst (
    .core_clk    (core_clk),
    .instr_en    (instr_req & instr_gnt),
    .instr_addr  (instr_addr[RAM_ADDR_WIDTH-1:0]),
    .instr_rdata (ram_line),
    .data_en     (data_hs & in_ram),
    .data_we     (data_we),
    .data_be     (data_be),
    .data_addr   (data_addr[RAM_ADDR_WIDTH-1:0]),
    .data_wdata  (data_wdata),
    .data_rdata  (ram_rdata)
  );

  if (INSTR_RDATA_WIDTH == 128) begin : g_line_fetch
    logic [1:0] word_sel;

    // Remember which word of the fetched line the core asked for.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n)                 word_sel <= 2'd0;
      else if (instr_req && instr_gnt) word_sel <= instr_addr[3:2];
    end

    assign instr_rdata = ram_line[{word_sel, 5'b0} +: 32];
  end else if (INSTR_RDATA_WIDTH == 32) begin : g_word_fetch
    assign instr_rdata = ram_line;
  end else begin : g_bad_width
    $fatal(1, "INSTR_RDATA_WIDTH must be 32 or 128");
  end

  assign data_rdata = (rd_sel == SEL_RAM) ? ram_rdata : periph_rdata;

  // Bus responses: rvalid one cycle after every handshake, plus read source.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      instr_rvalid <= 1'b0;
      data_rvalid  <= 1'b0;
      rd_sel       <= SEL_NONE;
      periph_rdata <= 32'h0;
    end else begin
      instr_rvalid <= instr_req & instr_gnt;
      data_rvalid  <= data_hs;
      if (data_hs) begin
        rd_sel       <= in_ram ? SEL_RAM : SEL_PERIPH;
        periph_rdata <= (!data_we && data_addr == TIMER_CNT_ADDR) ? timer_cnt : 32'h0;
      end
    end
  end

  // Timer: a count load clears the interrupt; a running count stops at zero and raises it.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      timer_cnt <= 32'h0;
      timer_run <= 1'b0;
      irq_timer <= 1'b0;
    end else if (wr_hs && data_addr == TIMER_CNT_ADDR) begin
      timer_cnt <= be_merge(timer_cnt, data_wdata, data_be);
      irq_timer <= 1'b0;
    end else if (wr_hs && data_addr == TIMER_CTRL_ADDR && data_be[0]) begin
      timer_run <= data_wdata[0];
    end else if (timer_run) begin
      if (timer_cnt < 32'd2) begin
        timer_cnt <= 32'h0;
        timer_run <= 1'b0;
        irq_timer <= 1'b1;
      end else begin
        timer_cnt <= timer_cnt - 32'd1;
      end
    end
  end

  // Status pulses and the held exit value.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      tests_passed <= 1'b0;
      tests_failed <= 1'b0;
      exit_valid   <= 1'b0;
      exit_value   <= 32'h0;
    end else begin
      tests_passed <= wr_hs && data_addr == TEST_STATUS_ADDR && wdata_masked == TEST_PASS_MAGIC;
      tests_failed <= wr_hs && data_addr == TEST_STATUS_ADDR && wdata_masked == TEST_FAIL_CODE;
      exit_valid   <= wr_hs && data_addr == EXIT_ADDR;
      if (wr_hs && data_addr == EXIT_ADDR) exit_value <= be_merge(exit_value, data_wdata, data_be);
    end
  end

  // Console: echo the low byte of each print write.
  always_ff @(posedge core_clk) begin
    if (core_rst_n && wr_hs && data_addr == PRINT_ADDR && data_be[0]) $write("%c", data_wdata[7:0]);
  end

endmodule

// File: rtl/cv32e20_sim_harness.sv
// Simulation harness: one core on a dual-port RAM with virtual peripherals
// for console output, pass/fail reporting, program exit and a timer interrupt.
module cv32e20_sim_harness
  import cv32e20_sim_pkg::*;
#(
  parameter int unsigned INSTR_RDATA_WIDTH = 32,
  parameter int unsigned RAM_ADDR_WIDTH    = 22,
  parameter logic [31:0] BOOT_ADDR         = 'h80,
  parameter logic [31:0] DM_HALTADDRESS    = 32'h1A11_0800,
  parameter int unsigned MHPMCounterNum    = 10,
  parameter int unsigned MHPMCounterWidth  = 40,
  parameter bit          RV32E             = 1'b0,
  parameter int          RV32M             = 2
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        fetch_enable_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  logic [3:0]  fetch_enable;
  logic        instr_req;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        irq_timer;

  assign fetch_enable = fetch_enable_i ? FETCH_ON : FETCH_OFF;

  cv32e20_core_model #(
    .DM_HALTADDRESS   (DM_HALTADDRESS),
    .MHPMCounterNum   (MHPMCounterNum),
    .MHPMCounterWidth (MHPMCounterWidth),
    .RV32E            (RV32E),
    .RV32M            (RV32M)
  ) core_inst (
    .core_clk     (core_clk),
    .core_rst_n   (core_rst_n),
    .fetch_enable (fetch_enable),
    .boot_addr    (BOOT_ADDR),
    .instr_req    (instr_req),
    .instr_gnt    (instr_gnt),
    .instr_rvalid (instr_rvalid),
    .instr_addr   (instr_addr),
    .instr_rdata  (instr_rdata),
    .instr_err    (instr_err),
    .data_req     (data_req),
    .data_gnt     (data_gnt),
    .data_rvalid  (data_rvalid),
    .data_we      (data_we),
    .data_be      (data_be),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_err     (data_err),
    .irq_software (1'b0),
    .irq_timer    (irq_timer),
    .irq_external (1'b0),
    .irq_nmi      (1'b0),
    .debug_req    (1'b0)
  );

  mm_ram #(
    .INSTR_RDATA_WIDTH (INSTR_RDATA_WIDTH),
    .RAM_ADDR_WIDTH    (RAM_ADDR_WIDTH)
  ) mm_ram_inst (
    .core_clk     (core_clk),
    .core_rst_n   (core_rst_n),
    .instr_req    (instr_req),
    .instr_gnt    (instr_gnt),
    .instr_rvalid (instr_rvalid),
    .instr_addr   (instr_addr),
    .instr_rdata  (instr_rdata),
    .instr_err    (instr_err),
    .data_req     (data_req),
    .data_gnt     (data_gnt),
    .data_rvalid  (data_rvalid),
    .data_we      (data_we),
    .data_be      (data_be),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_err     (data_err),
    .irq_timer    (irq_timer),
    .tests_passed (tests_passed_o),
    .tests_failed (tests_failed_o),
    .exit_valid   (exit_valid_o),
    .exit_value   (exit_value_o)
  );

endmodule

// File: tb/tb_cv32e20_sim_harness.sv
// Directed bench for cv32e20_sim_harness. The data port is driven by forcing
// the harness bus nets; instruction fetch is observed on the harness nets.
module tb_cv32e20_sim_harness;

  logic        core_clk;
  logic        core_rst_n;
  logic        fe32;
  logic        fe128;
  logic        passed32, failed32, exit_valid32;
  logic [31:0] exit_value32;
  logic        passed128, failed128, exit_valid128;
  logic [31:0] exit_value128;

  logic        req32, req128;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;

  int n_assert;
  int n_fail;

  cv32e20_sim_harness #(.INSTR_RDATA_WIDTH(32)) dut (
    .core_clk       (core_clk),
    .core_rst_n     (core_rst_n),
    .fetch_enable_i (fe32),
    .tests_passed_o (passed32),
    .tests_failed_o (failed32),
    .exit_valid_o   (exit_valid32),
    .exit_value_o   (exit_value32)
  );

  cv32e20_sim_harness #(.INSTR_RDATA_WIDTH(128)) dut128 (
    .core_clk       (core_clk),
    .core_rst_n     (core_rst_n),
    .fetch_enable_i (fe128),
    .tests_passed_o (passed128),
    .tests_failed_o (failed128),
    .exit_valid_o   (exit_valid128),
    .exit_value_o   (exit_value128)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One data-port transfer; returns #1 after the handshake edge.
  task automatic bus(input bit to128, input bit we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wdata);
    bus_we    = we;
    bus_be    = be;
    bus_addr  = addr;
    bus_wdata = wdata;
    req32     = !to128;
    req128    = to128;
    @(posedge core_clk); #1;
    req32     = 1'b0;
    req128    = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    bus(1'b0, 1'b1, 4'hF, addr, wdata);
  endtask

  task automatic rd(input logic [31:0] addr);
    bus(1'b0, 1'b0, 4'h0, addr, 32'h0);
  endtask

  task automatic tick();
    @(posedge core_clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    core_rst_n = 1'b0;
    fe32       = 1'b0;
    fe128      = 1'b0;
    req32      = 1'b0;
    req128     = 1'b0;
    bus_we     = 1'b0;
    bus_be     = 4'h0;
    bus_addr   = 32'h0;
    bus_wdata  = 32'h0;

    force dut.data_req      = req32;
    force dut.data_we       = bus_we;
    force dut.data_be       = bus_be;
    force dut.data_addr     = bus_addr;
    force dut.data_wdata    = bus_wdata;
    force dut128.data_req   = req128;
    force dut128.data_we    = bus_we;
    force dut128.data_be    = bus_be;
    force dut128.data_addr  = bus_addr;
    force dut128.data_wdata = bus_wdata;

    repeat (3) @(posedge core_clk);
    #1;
    check("rst_passed",     32'(passed32),          32'h0);
    check("rst_failed",     32'(failed32),          32'h0);
    check("rst_exit_valid", 32'(exit_valid32),      32'h0);
    check("rst_exit_value", exit_value32,           32'h0);
    check("rst_irq",        32'(dut.irq_timer),     32'h0);
    check("rst_rvalid",     32'(dut.data_rvalid),   32'h0);
    core_rst_n = 1'b1;
    tick();

    // RAM word store, load, byte store
    wr(32'h100, 32'h1234_5678);
    check("wr_rvalid", 32'(dut.data_rvalid), 32'h1);
    rd(32'h100);
    check("rd_rvalid", 32'(dut.data_rvalid), 32'h1);
    check("rd_word",   dut.data_rdata,       32'h1234_5678);
    tick();
    check("rvalid_single", 32'(dut.data_rvalid), 32'h0);
    bus(1'b0, 1'b1, 4'b0010, 32'h101, 32'h0000_AB00);
    rd(32'h100);
    check("rd_byte_merge", dut.data_rdata, 32'h1234_AB78);

    // Test status register
    wr(32'h2000_0000, 32'd123456789);
    check("pass_pulse",    32'(passed32), 32'h1);
    check("pass_no_fail",  32'(failed32), 32'h0);
    tick();
    check("pass_one_cyc",  32'(passed32), 32'h0);
    wr(32'h2000_0000, 32'd1);
    check("fail_pulse",    32'(failed32), 32'h1);
    check("fail_no_pass",  32'(passed32), 32'h0);
    tick();
    check("fail_one_cyc",  32'(failed32), 32'h0);
    wr(32'h2000_0000, 32'd5);
    check("other_no_pass", 32'(passed32), 32'h0);
    check("other_no_fail", 32'(failed32), 32'h0);
    wr(32'h2000_0000, 32'd123456789);
    check("b2b_pass_1",    32'(passed32), 32'h1);
    wr(32'h2000_0000, 32'd123456789);
    check("b2b_pass_2",    32'(passed32), 32'h1);
    tick();
    check("b2b_pass_end",  32'(passed32), 32'h0);

    // Exit register
    wr(32'h2000_0004, 32'd0);
    check("exit_valid_1", 32'(exit_valid32), 32'h1);
    check("exit_value_1", exit_value32,      32'd0);
    wr(32'h2000_0004, 32'd7);
    check("exit_valid_2", 32'(exit_valid32), 32'h1);
    check("exit_value_2", exit_value32,      32'd7);
    tick();
    check("exit_valid_end", 32'(exit_valid32), 32'h0);
    check("exit_value_hold", exit_value32,     32'd7);

    // Console print
    wr(32'h1000_0000, 32'h48);
    $display("");
    check("print_no_pass", 32'(passed32),     32'h0);
    check("print_no_fail", 32'(failed32),     32'h0);
    check("print_no_exit", 32'(exit_valid32), 32'h0);

    // Timer
    wr(32'h1500_0000, 32'd3);
    rd(32'h1500_0000);
    check("timer_cnt_rd", dut.data_rdata, 32'd3);
    wr(32'h1500_0004, 32'd1);
    check("timer_irq_start", 32'(dut.irq_timer), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("timer_irq_c%0d", k), 32'(dut.irq_timer), (k == 3) ? 32'h1 : 32'h0);
    end
    tick();
    check("timer_irq_hold", 32'(dut.irq_timer), 32'h1);
    rd(32'h1500_0000);
    check("timer_cnt_zero", dut.data_rdata,     32'd0);
    check("timer_irq_hold2", 32'(dut.irq_timer), 32'h1);
    wr(32'h1500_0000, 32'd10);
    check("timer_irq_clear", 32'(dut.irq_timer), 32'h0);

    // Unmapped addresses and the RAM boundary
    wr(32'h3000_0000, 32'hFFFF_FFFF);
    rd(32'h3000_0000);
    check("unmapped_rd",  dut.data_rdata,     32'h0);
    check("unmapped_err", 32'(dut.data_err),  32'h0);
    wr(32'h0040_0100, 32'hDEAD_BEEF);
    rd(32'h100);
    check("ram_no_alias", dut.data_rdata, 32'h1234_AB78);
    rd(32'h0040_0100);
    check("above_ram_rd", dut.data_rdata, 32'h0);

    // Reset in the middle of a response
    wr(32'h2000_0004, 32'd9);
    check("exit_before_rst", 32'(exit_valid32), 32'h1);
    #1 core_rst_n = 1'b0;
    #1;
    check("mid_rst_exit_valid", 32'(exit_valid32),    32'h0);
    check("mid_rst_exit_value", exit_value32,         32'h0);
    check("mid_rst_rvalid",     32'(dut.data_rvalid), 32'h0);
    @(negedge core_clk);
    core_rst_n = 1'b1;
    tick();
    rd(32'h100);
    check("ram_kept", dut.data_rdata, 32'h1234_AB78);
    rd(32'h1500_0000);
    check("timer_cnt_rst", dut.data_rdata, 32'h0);

    // 32-bit fetch from the boot vector, old data on same-cycle write
    wr(32'h80, 32'hCAFE_0080);
    wr(32'h84, 32'h1111_2222);
    fe32 = 1'b1;
    tick();
    check("boot_req",  32'(dut.instr_req), 32'h1);
    check("boot_addr", dut.instr_addr,     32'h80);
    tick();
    check("fetch0_rvalid", 32'(dut.instr_rvalid), 32'h1);
    check("fetch0_rdata",  dut.instr_rdata,       32'hCAFE_0080);
    check("fetch1_addr",   dut.instr_addr,        32'h84);
    wr(32'h84, 32'h3333_4444);
    check("instr_old_data", dut.instr_rdata, 32'h1111_2222);
    rd(32'h84);
    check("data_new_data",  dut.data_rdata,  32'h3333_4444);

    // 128-bit line fetch with word select
    bus(1'b1, 1'b1, 4'hF, 32'h80, 32'hA0A1_A2A3);
    bus(1'b1, 1'b1, 4'hF, 32'h84, 32'hB0B1_B2B3);
    bus(1'b1, 1'b1, 4'hF, 32'h88, 32'hC0C1_C2C3);
    bus(1'b1, 1'b1, 4'hF, 32'h8C, 32'hD0D1_D2D3);
    check("l128_mem_byte", 32'(dut128.mm_ram_inst.dp_ram_inst.mem[136]), 32'hC3);
    fe128 = 1'b1;
    tick();
    check("l128_boot_addr", dut128.instr_addr, 32'h80);
    tick();
    check("l128_w0", dut128.instr_rdata, 32'hA0A1_A2A3);
    tick();
    check("l128_w1", dut128.instr_rdata, 32'hB0B1_B2B3);
    tick();
    check("l128_w2", dut128.instr_rdata, 32'hC0C1_C2C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
